systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 110 +++++++++++
 tb/tb_systolic_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads 3x3 operands, feeds them to a systolic array and collects its result words
module systolic_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int WORDS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en,
  input  logic        ld_sel,
  input  logic [1:0]  ld_idx,
  input  logic [23:0] ld_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [23:0] arr_a,
  output logic [23:0] arr_b,
  output logic        arr_valid_in,
  input  logic        arr_valid_out,
  input  logic [47:0] arr_c,
  input  logic [1:0]  rd_idx,
  output logic [47:0] res_data
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FEED, COLLECT, DONE} state_t;
  state_t state;
  logic [WORDS-1:0][23:0] a, b;
  logic [WORDS-1:0][47:0] res;
  logic [1:0] k, kn, cnt;
  logic [TW-1:0] tmo;
  logic wr;
  logic [23:0] a0, b0;
  // word 0 is forwarded so a load in the start cycle reaches the first feed word
  always_comb begin
    wr = ld_en && ld_idx != 2'd3;
    kn = k + 2'd1;
    a0 = (wr && !ld_sel && ld_idx == 2'd0) ? ld_data : a[0];
    b0 = (wr && ld_sel && ld_idx == 2'd0) ? ld_data : b[0];
    res_data = (rd_idx == 2'd3) ? '0 : res[rd_idx];
  end
  // run sequencer with registered array-side and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      res <= '0;
      k <= '0;
      cnt <= '0;
      tmo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      arr_valid_in <= 1'b0;
      arr_a <= '0;
      arr_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr && !ld_sel) a[ld_idx] <= ld_data;
          if (wr && ld_sel) b[ld_idx] <= ld_data;
          if (start) begin
            state <= FEED;
            k <= '0;
            cnt <= '0;
            err <= 1'b0;
            busy <= 1'b1;
            arr_valid_in <= 1'b1;
            arr_a <= a0;
            arr_b <= b0;
          end
        end
        FEED: begin
          k <= kn;
          if (k == 2'(WORDS - 1)) begin
            state <= COLLECT;
            tmo <= '0;
            arr_valid_in <= 1'b0;
            arr_a <= '0;
            arr_b <= '0;
          end else begin
            arr_a <= a[kn];
            arr_b <= b[kn];
          end
        end
        COLLECT: begin
          tmo <= tmo + 1'b1;
          if (arr_valid_out) begin
            res[cnt] <= arr_c;
            cnt <= cnt + 2'd1;
          end
          if (arr_valid_out && cnt == 2'(WORDS - 1)) begin
            state <= DONE;
            done <= 1'b1;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed vector bench for systolic_ctrl with a hand-driven mock array
module tb_systolic_ctrl;
  logic clk = 0, reset = 1, ld_en = 0, ld_sel = 0, start = 0, arr_valid_out = 0;
  logic [1:0] ld_idx = 0, rd_idx = 0;
  logic [23:0] ld_data = 0;
  logic [47:0] arr_c = 0;
  logic busy, done, err, arr_valid_in;
  logic [23:0] arr_a, arr_b;
  logic [47:0] res_data;
  int total = 0, bad = 0, n, nd;

  systolic_ctrl #(.TIMEOUT(16), .WORDS(3)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx),
    .ld_data(ld_data), .start(start), .busy(busy), .done(done), .err(err),
    .arr_a(arr_a), .arr_b(arr_b), .arr_valid_in(arr_valid_in),
    .arr_valid_out(arr_valid_out), .arr_c(arr_c), .rd_idx(rd_idx), .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct {logic sel; logic [1:0] idx; logic [23:0] data;} ld_t;
  typedef struct {logic v; logic [23:0] a; logic [23:0] b;} fd_t;
  ld_t lds[7];
  fd_t fds[4];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic feed_check(input string nm);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({nm, "_v"}, arr_valid_in, fds[i].v);
      chk({nm, "_a"}, arr_a, fds[i].a);
      chk({nm, "_b"}, arr_b, fds[i].b);
      tick;
    end
  endtask

  task automatic check_res(input string nm, input logic [47:0] w0, input logic [47:0] w1, input logic [47:0] w2);
    logic [47:0] e[4];
    e = '{w0, w1, w2, 48'h0};
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1 chk(nm, res_data, e[i]);
    end
  endtask

  task automatic send(input logic [47:0] w, input int gap);
    arr_valid_out = 1;
    arr_c = w;
    tick;
    arr_valid_out = 0;
    arr_c = 0;
    repeat (gap) tick;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_wait", 0, 1);
  endtask

  initial begin
    lds = '{'{1'b0, 2'd0, 24'h070401}, '{1'b0, 2'd1, 24'h080502}, '{1'b0, 2'd2, 24'h090603},
            '{1'b1, 2'd0, 24'h030102}, '{1'b1, 2'd1, 24'h070504}, '{1'b1, 2'd2, 24'h080906},
            '{1'b0, 2'd3, 24'hffffff}};
    fds = '{'{1'b1, 24'h070401, 24'h030102}, '{1'b1, 24'h080502, 24'h070504},
            '{1'b1, 24'h090603, 24'h080906}, '{1'b0, 24'h0, 24'h0}};
    repeat (2) tick;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_v", arr_valid_in, 0);
    chk("rst_a", arr_a, 0);
    chk("rst_b", arr_b, 0);
    check_res("rst_res", 0, 0, 0);
    reset = 0;
    tick;
    // run 1: table loads, array answers 4 cycles after the last feed word
    for (int i = 0; i < 7; i++) begin
      ld_en = 1;
      ld_sel = lds[i].sel;
      ld_idx = lds[i].idx;
      ld_data = lds[i].data;
      tick;
    end
    ld_en = 0;
    start_run;
    feed_check("r1");
    repeat (2) tick;
    send(48'h000100020003, 0);
    send(48'h000400050006, 0);
    send(48'h000700080009, 0);
    @(negedge clk);
    chk("r1_done", done, 1);
    chk("r1_busy", busy, 1);
    chk("r1_err", err, 0);
    tick;
    @(negedge clk);
    chk("r1_done_end", done, 0);
    chk("r1_idle", busy, 0);
    check_res("r1_res", 48'h000100020003, 48'h000400050006, 48'h000700080009);
    tick;
    // run 2: array never answers
    start_run;
    wait_done(40, n);
    chk("r2_cycles", 48'(n), 19);
    chk("r2_err", err, 1);
    tick;
    @(negedge clk);
    chk("r2_idle", busy, 0);
    chk("r2_sticky", err, 1);
    check_res("r2_res", 48'h000100020003, 48'h000400050006, 48'h000700080009);
    tick;
    // run 3: start clears err, strays during FEED are ignored
    start_run;
    @(negedge clk);
    chk("r3_clr", err, 0);
    chk("r3_a0", arr_a, 24'h070401);
    tick;
    start = 1;
    ld_en = 1;
    ld_sel = 1;
    ld_idx = 0;
    ld_data = 24'hffffff;
    arr_valid_out = 1;
    arr_c = 48'hdeaddeaddead;
    @(negedge clk);
    chk("r3_a1", arr_a, 24'h080502);
    tick;
    start = 0;
    ld_en = 0;
    arr_valid_out = 0;
    arr_c = 0;
    @(negedge clk);
    chk("r3_a2", arr_a, 24'h090603);
    chk("r3_v2", arr_valid_in, 1);
    tick;
    send(48'h111111111111, 0);
    send(48'h222222222222, 0);
    send(48'h333333333333, 0);
    @(negedge clk);
    chk("r3_done", done, 1);
    chk("r3_err", err, 0);
    tick;
    check_res("r3_res", 48'h111111111111, 48'h222222222222, 48'h333333333333);
    // run 4: load and start together, gapped results
    ld_en = 1;
    ld_sel = 0;
    ld_idx = 0;
    ld_data = 24'h112233;
    start = 1;
    tick;
    ld_en = 0;
    start = 0;
    @(negedge clk);
    chk("r4_a0", arr_a, 24'h112233);
    chk("r4_b0", arr_b, 24'h030102);
    tick;
    @(negedge clk);
    chk("r4_a1", arr_a, 24'h080502);
    repeat (2) tick;
    send(48'haaaa00000001, 2);
    send(48'hbbbb00000002, 2);
    send(48'hcccc00000003, 0);
    @(negedge clk);
    chk("r4_done", done, 1);
    chk("r4_err", err, 0);
    tick;
    check_res("r4_res", 48'haaaa00000001, 48'hbbbb00000002, 48'hcccc00000003);
    // run 5: reset in the second FEED cycle
    start_run;
    tick;
    reset = 1;
    tick;
    reset = 0;
    @(negedge clk);
    chk("r5_v", arr_valid_in, 0);
    chk("r5_busy", busy, 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("r5_no_done", 48'(nd), 0);
    tick;
    check_res("r5_res", 0, 0, 0);
    start_run;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r5_fv", arr_valid_in, 1);
      chk("r5_fa", arr_a, 0);
      chk("r5_fb", arr_b, 0);
      tick;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
